polygon_area: RTL and testbench
===============================

# polygon_area

Downstream consumer of the point-sort engine's ordered vertex stream. It accepts `point_num` consecutive vertex beats (`valid`, `Xin`, `Yin`) in polygon order and accumulates the shoelace sum. It outputs the enclosed area, rounded down, as a one-cycle result pulse. It optionally flags non-convex input order.

## Interface
- `NPTS_MAX`, 6: largest legal `point_num`.
- `CW`, 10: coordinate width, unsigned.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `valid` input 1: vertex beat qualifier; one vertex per high cycle.
- `Xin` input CW: vertex x.
- `Yin` input CW: vertex y.
- `point_num` input 3: vertex count; sampled on the first beat of a polygon.
- `area_valid` output 1: one-cycle result strobe.
- `area` output 2*CW: floor(|shoelace sum| / 2); held until the next result.
- `convex_err` output 1: valid with `area_valid`; 1 = non-convex ordering.

## Operation
- Reset values: state IDLE, all registers 0, `area_valid`=0, `area`=0, `convex_err`=0.
- FSM states:
  - IDLE:
    - On `valid`=1: store P0 and Pprev, latch `point_num` (0 is treated as 1), set beat count to 1, clear the accumulator, go to ACC.
    - A latched count of 1 goes to CLOSE directly.
  - ACC:
    - Each `valid` beat Pi adds xprev·yi − xi·yprev to the accumulator, increments the count, and shifts Pprev.
    - The second beat also stores P1.
    - When the count reaches the latched `point_num`, go to CLOSE.
    - `valid`=0 in ACC aborts: go to IDLE with no result and no output change.
  - CLOSE:
    - Adds the wrap term xlast·y0 − x0·ylast.
    - Goes to OUT.
    - `valid` is ignored.
  - OUT:
    - Registers `area` = |acc| >> 1 and `convex_err`.
    - Pulses `area_valid` for one cycle.
    - Returns to IDLE.
    - A `valid` beat in this cycle is dropped, not treated as a new P0.
- Arithmetic:
  - Products are CW×CW unsigned (20 bits).
  - Each term is a 21-bit signed value.
  - The accumulator is 24-bit signed, so there is no overflow for 6 terms.
  - The magnitude is at most 2,093,058, so `area` fits in 20 bits.
- Degenerate input:
  - `point_num` 1 or 2 gives area 0 and `convex_err`=0.
  - Collinear vertices give area 0.
- Orientation: CW and CCW input give the same area.

## Timing
- Last vertex beat at cycle T: CLOSE at T+1, `area_valid`=1 at T+2. `area` and `convex_err` are valid from T+2 and held afterwards.
- Minimum gap between polygons: 2 idle cycles after the last beat. The upstream engine's IDLE and STORE_P phases guarantee this.
- No backpressure: the block is always ready in IDLE and ACC.
- Reset mid-operation clears everything immediately. A partially received polygon produces no result.

## Configuration
- With `PAREA_CONVEX_CHECK_EN` defined:
  - For each beat i ≥ 2, compute the turn cross of (Pi-1 − Pi-2) × (Pi − Pi-1).
  - In CLOSE, compute two more in parallel: the turn at Plast and the turn at P0, using the stored P1.
  - Set sticky flags `seen_pos` and `seen_neg`. Zero crosses are ignored.
  - `convex_err` = `seen_pos` & `seen_neg`, registered in OUT.
- Without the macro:
  - No turn logic and no P1 or Pprev2 registers.
  - The `convex_err` port remains and is tied to 0.

## Structure
- Package `pa_pkg` holds:
  - the state enum: IDLE, ACC, CLOSE, OUT;
  - width constants: CW, TERM_W = 2·CW+1, ACC_W = 2·CW+4;
  - the `point_t` struct {x, y}.
- Sub-module `shoelace_term`: combinational xa·yb − xb·ya, signed TERM_W result.
  - Instanced once for the accumulator.
  - Under the macro, reused for the turn crosses via edge-difference inputs (CW+1 signed).

## Test plan
- Square (0,0),(10,0),(10,10),(0,10), `point_num`=4: `area`=100 at T+2, `convex_err`=0.
- Triangle (0,0),(3,0),(0,3): sum 9, so `area`=4 (floor). Same triangle given clockwise: `area`=4.
- Full-range square (0,0),(1023,0),(1023,1023),(0,1023): `area`=1046529.
- Non-convex quad (0,0),(10,0),(2,2),(0,10) with macro on: `area`=20, `convex_err`=1. With macro off: `convex_err`=0.
- `valid` drops after 2 of 5 beats, then a fresh square is sent: the first polygon gives no `area_valid`; the square gives 100.
- `reset` asserted mid-ACC: outputs 0 immediately. A following hexagon (0,0),(4,0),(6,2),(4,4),(0,4),(-) is replaced by the legal (0,0),(4,0),(6,2),(4,4),(0,4),(0,2) and must give `area`=20.

Source files
------------

// File: rtl/pa_pkg.sv
// Shared types and widths for the polygon_area shoelace accumulator.
// Holds the FSM state enum, the vertex struct and signed-difference helpers.
package pa_pkg;

    localparam int NPTS_MAX = 6;
    localparam int CW       = 10;
    localparam int TERM_W   = 2 * CW + 1;
    localparam int ACC_W    = 2 * CW + 4;
    localparam int DW       = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        CLOSE = 2'd2,
        OUT   = 2'd3
    } pa_state_e;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } point_t;

    // Unsigned coordinate as a non-negative DW-bit signed operand.
    function automatic logic signed [DW-1:0] widen(input logic [CW-1:0] v);
        return $signed({1'b0, v});
    endfunction

    function automatic logic signed [DW-1:0] edge_diff(input logic [CW-1:0] a,
                                                       input logic [CW-1:0] b);
        return widen(a) - widen(b);
    endfunction

endpackage

// File: rtl/shoelace_term.sv
// Combinational cross term xa*yb - xb*ya on signed IW-bit operands.
// Operands are sign-extended to full width so neither product can overflow.
module shoelace_term #(
    parameter int IW = pa_pkg::DW,
    parameter int OW = pa_pkg::TERM_W
) (
    input  logic signed [IW-1:0] xa,
    input  logic signed [IW-1:0] ya,
    input  logic signed [IW-1:0] xb,
    input  logic signed [IW-1:0] yb,
    output logic signed [OW-1:0] term
);

    localparam int PW = 2 * IW + 1;

    logic signed [PW-1:0] xa_e, ya_e, xb_e, yb_e;
    logic signed [PW-1:0] p_ab, p_ba, diff;

    assign xa_e = PW'(xa);
    assign ya_e = PW'(ya);
    assign xb_e = PW'(xb);
    assign yb_e = PW'(yb);

    assign p_ab = xa_e * yb_e;
    assign p_ba = xb_e * ya_e;
    assign diff = p_ab - p_ba;
    assign term = OW'(diff);

endmodule

// File: rtl/polygon_area.sv
// Shoelace area of an ordered vertex stream, reported as a one-cycle pulse.
// Optional non-convex order detection is built with PAREA_CONVEX_CHECK_EN.
module polygon_area
    import pa_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [CW-1:0]       Xin,
    input  logic [CW-1:0]       Yin,
    input  logic [2:0]          point_num,
    output logic                area_valid,
    output logic [2*CW-1:0]     area,
    output logic                convex_err,
    output pa_state_e           dbg_state
);

    // Handshake: valid-only stream, no ready. Every cycle with valid=1 in IDLE
    // or ACC is one vertex; a low valid inside ACC abandons the polygon, and
    // valid is ignored in CLOSE and OUT.

    pa_state_e state, state_nxt;

    point_t p0, pprev, pin, close_b;
    logic [2:0] cnt, npts, npts_in, cnt_inc;
    logic signed [ACC_W-1:0] acc, acc_sum;
    logic [ACC_W-1:0] mag;
    logic [2*CW-1:0] area_nxt;
    logic signed [TERM_W-1:0] term;
    logic take_first, take_beat;
    logic cvx_nxt;

    assign pin        = '{x: Xin, y: Yin};
    assign npts_in    = (point_num == 3'd0) ? 3'd1 : point_num;
    assign cnt_inc    = cnt + 3'd1;
    assign take_first = (state == IDLE) && valid;
    assign take_beat  = (state == ACC) && valid;
    assign dbg_state  = state;

    // ACC adds the Pprev->Pin edge; CLOSE reuses the same term for Plast->P0.
    assign close_b = (state == CLOSE) ? p0 : pin;

    shoelace_term #(.IW(DW), .OW(TERM_W)) u_acc_term (
        .xa   (widen(pprev.x)),
        .ya   (widen(pprev.y)),
        .xb   (widen(close_b.x)),
        .yb   (widen(close_b.y)),
        .term (term)
    );

    assign acc_sum  = acc + ACC_W'(term);
    assign mag      = acc_sum[ACC_W-1] ? ACC_W'(-acc_sum) : ACC_W'(acc_sum);
    assign area_nxt = (2*CW)'(mag >> 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nxt = (npts_in == 3'd1) ? CLOSE : ACC;
                end
            end
            ACC: begin
                if (!valid) begin
                    state_nxt = IDLE;
                end else if (cnt_inc == npts) begin
                    state_nxt = CLOSE;
                end
            end
            CLOSE:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            p0         <= '0;
            pprev      <= '0;
            cnt        <= '0;
            npts       <= '0;
            acc        <= '0;
            area       <= '0;
            area_valid <= 1'b0;
            convex_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            area_valid <= 1'b0;
            if (take_first) begin
                p0    <= pin;
                pprev <= pin;
                npts  <= npts_in;
                cnt   <= 3'd1;
                acc   <= '0;
            end
            if (take_beat) begin
                acc   <= acc_sum;
                cnt   <= cnt_inc;
                pprev <= pin;
            end
            // Result lands on the CLOSE->OUT edge so it is visible during OUT.
            if (state == CLOSE) begin
                area       <= area_nxt;
                convex_err <= cvx_nxt;
                area_valid <= 1'b1;
            end
        end
    end

`ifdef PAREA_CONVEX_CHECK_EN
    point_t p1, pprev2;
    logic seen_pos, seen_neg;
    logic signed [DW-1:0] a_d1x, a_d1y, a_d2x, a_d2y;
    logic signed [DW-1:0] b_d1x, b_d1y, b_d2x, b_d2y;
    logic signed [TERM_W:0] turn_a, turn_b;
    logic pos_a, neg_a, pos_b, neg_b;
    logic turn_chk;

    // Turn at Pprev (or Plast in CLOSE): incoming edge vs outgoing edge.
    assign a_d1x = edge_diff(pprev.x, pprev2.x);
    assign a_d1y = edge_diff(pprev.y, pprev2.y);
    assign a_d2x = edge_diff(close_b.x, pprev.x);
    assign a_d2y = edge_diff(close_b.y, pprev.y);

    // Turn at P0: closing edge Plast->P0 vs first edge P0->P1.
    assign b_d1x = edge_diff(p0.x, pprev.x);
    assign b_d1y = edge_diff(p0.y, pprev.y);
    assign b_d2x = edge_diff(p1.x, p0.x);
    assign b_d2y = edge_diff(p1.y, p0.y);

    // One extra bit over TERM_W: edge-difference crosses reach +/-2*1023^2.
    shoelace_term #(.IW(DW), .OW(TERM_W + 1)) u_turn_a (
        .xa(a_d1x), .ya(a_d1y), .xb(a_d2x), .yb(a_d2y), .term(turn_a)
    );

    shoelace_term #(.IW(DW), .OW(TERM_W + 1)) u_turn_b (
        .xa(b_d1x), .ya(b_d1y), .xb(b_d2x), .yb(b_d2y), .term(turn_b)
    );

    assign pos_a    = !turn_a[TERM_W] && (turn_a != '0);
    assign neg_a    = turn_a[TERM_W];
    assign pos_b    = !turn_b[TERM_W] && (turn_b != '0);
    assign neg_b    = turn_b[TERM_W];
    assign turn_chk = take_beat && (cnt >= 3'd2);

    assign cvx_nxt = (npts >= 3'd3) && (seen_pos || pos_a || pos_b)
                                    && (seen_neg || neg_a || neg_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1       <= '0;
            pprev2   <= '0;
            seen_pos <= 1'b0;
            seen_neg <= 1'b0;
        end else begin
            if (take_first) begin
                pprev2   <= '0;
                seen_pos <= 1'b0;
                seen_neg <= 1'b0;
            end
            if (take_beat) begin
                pprev2 <= pprev;
                if (cnt == 3'd1) begin
                    p1 <= pin;
                end
            end
            if (turn_chk) begin
                seen_pos <= seen_pos || pos_a;
                seen_neg <= seen_neg || neg_a;
            end
        end
    end
`else
    assign cvx_nxt = 1'b0;
`endif

endmodule

// File: tb/tb_polygon_area.sv
// Directed table-driven bench for polygon_area: area pulse timing, floor,
// orientation, degenerate counts, abort, reset mid-polygon, dropped beats.
module tb_polygon_area;
    import pa_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid;
    logic [CW-1:0]   Xin, Yin;
    logic [2:0]      point_num;
    logic            area_valid;
    logic [2*CW-1:0] area;
    logic            convex_err;
    pa_state_e       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2*CW-1:0] exp_q[$];

`ifdef PAREA_CONVEX_CHECK_EN
    localparam logic CVX_ON = 1'b1;
`else
    localparam logic CVX_ON = 1'b0;
`endif

    typedef struct {
        string           name;
        logic [2:0]      pn;
        int              nb;
        logic [5:0][9:0] xs;
        logic [5:0][9:0] ys;
        logic [2*CW-1:0] exp_area;
        logic            exp_cvx;
    } vec_t;

    vec_t vecs[$];

    polygon_area dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .Xin        (Xin),
        .Yin        (Yin),
        .point_num  (point_num),
        .area_valid (area_valid),
        .area       (area),
        .convex_err (convex_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0][9:0] pk(input int c0, input int c1, input int c2,
                                          input int c3, input int c4, input int c5);
        logic [5:0][9:0] r;
        r[0] = 10'(c0); r[1] = 10'(c1); r[2] = 10'(c2);
        r[3] = 10'(c3); r[4] = 10'(c4); r[5] = 10'(c5);
        return r;
    endfunction

    function automatic vec_t mk(input string nm, input logic [2:0] pn, input int nb,
                                input logic [5:0][9:0] xs, input logic [5:0][9:0] ys,
                                input logic [2*CW-1:0] a, input logic c);
        vec_t v;
        v.name = nm; v.pn = pn; v.nb = nb; v.xs = xs; v.ys = ys;
        v.exp_area = a; v.exp_cvx = c;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [9:0] x, input logic [9:0] y, input logic [2:0] pn);
        valid = 1'b1; Xin = x; Yin = y; point_num = pn;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Called at T+1 (#1 after the last-beat edge).
    task automatic check_result(input string nm, input logic exp_cvx);
        logic [2*CW-1:0] exp_a;
        check({nm, "_av_close"}, 32'(area_valid), 32'd0);
        @(posedge clk); #1;
        exp_a = exp_q.pop_front();
        check({nm, "_av"}, 32'(area_valid), 32'd1);
        check({nm, "_area"}, 32'(area), 32'(exp_a));
        check({nm, "_cvx"}, 32'(convex_err), 32'(exp_cvx));
        @(posedge clk); #1;
        check({nm, "_av_drop"}, 32'(area_valid), 32'd0);
        check({nm, "_area_hold"}, 32'(area), 32'(exp_a));
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.nb; i++) begin
            beat(v.xs[i], v.ys[i], v.pn);
        end
        exp_q.push_back(v.exp_area);
        check_result(v.name, v.exp_cvx);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (area_valid) pulses++;
        end
    endtask

    initial begin
        int pulses;
        vec_t square, hexa;

        square = mk("square", 3'd4, 4, pk(0, 10, 10, 0, 0, 0), pk(0, 0, 10, 10, 0, 0), 20'd100, 1'b0);
        hexa   = mk("hexagon", 3'd6, 6, pk(0, 4, 6, 4, 0, 0), pk(0, 0, 2, 4, 4, 2), 20'd20, 1'b0);
        vecs.push_back(square);
        vecs.push_back(mk("tri_ccw", 3'd3, 3, pk(0, 3, 0, 0, 0, 0), pk(0, 0, 3, 0, 0, 0), 20'd4, 1'b0));
        vecs.push_back(mk("tri_cw", 3'd3, 3, pk(0, 0, 3, 0, 0, 0), pk(0, 3, 0, 0, 0, 0), 20'd4, 1'b0));
        vecs.push_back(mk("full_sq", 3'd4, 4, pk(0, 1023, 1023, 0, 0, 0), pk(0, 0, 1023, 1023, 0, 0), 20'd1046529, 1'b0));
        vecs.push_back(mk("full_tri", 3'd3, 3, pk(1023, 0, 0, 0, 0, 0), pk(0, 1023, 0, 0, 0, 0), 20'd523264, 1'b0));
        vecs.push_back(mk("concave", 3'd4, 4, pk(0, 10, 2, 0, 0, 0), pk(0, 0, 2, 10, 0, 0), 20'd20, CVX_ON));
        vecs.push_back(mk("two_pts", 3'd2, 2, pk(5, 9, 0, 0, 0, 0), pk(5, 1, 0, 0, 0, 0), 20'd0, 1'b0));
        vecs.push_back(mk("sq_cw", 3'd4, 4, pk(0, 0, 10, 10, 0, 0), pk(0, 10, 10, 0, 0, 0), 20'd100, 1'b0));
        vecs.push_back(mk("pn_zero", 3'd0, 1, pk(7, 0, 0, 0, 0, 0), pk(3, 0, 0, 0, 0, 0), 20'd0, 1'b0));
        vecs.push_back(mk("collinear", 3'd3, 3, pk(0, 2, 4, 0, 0, 0), pk(0, 2, 4, 0, 0, 0), 20'd0, 1'b0));
        vecs.push_back(hexa);

        reset = 1'b1; valid = 1'b0; Xin = '0; Yin = '0; point_num = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_av", 32'(area_valid), 32'd0);
        check("rst_area", 32'(area), 32'd0);
        check("rst_cvx", 32'(convex_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort: 2 of 5 beats then valid drops; no pulse, area holds 20.
        beat(10'd1, 10'd1, 3'd5);
        beat(10'd5, 10'd1, 3'd5);
        count_pulses(6, pulses);
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_area_hold", 32'(area), 32'd20);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        run_vec(square);

        // Valid held high through CLOSE and OUT must not start a new polygon.
        beat(10'd0, 10'd0, 3'd3);
        beat(10'd3, 10'd0, 3'd3);
        beat(10'd0, 10'd3, 3'd3);
        valid = 1'b1; Xin = 10'd100; Yin = 10'd100; point_num = 3'd1;
        check("drop_av_close", 32'(area_valid), 32'd0);
        @(posedge clk); #1;
        check("drop_av", 32'(area_valid), 32'd1);
        check("drop_area", 32'(area), 32'd4);
        @(posedge clk); #1;
        valid = 1'b0;
        check("drop_state", 32'(dbg_state), 32'(IDLE));
        count_pulses(4, pulses);
        check("drop_pulses", 32'(pulses), 32'd0);

        // Asynchronous reset mid-ACC, between clock edges.
        beat(10'd0, 10'd0, 3'd6);
        beat(10'd4, 10'd0, 3'd6);
        valid = 1'b1; Xin = 10'd6; Yin = 10'd2; point_num = 3'd6;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_area", 32'(area), 32'd0);
        check("mid_rst_av", 32'(area_valid), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        count_pulses(3, pulses);
        check("mid_rst_pulses", 32'(pulses), 32'd0);
        run_vec(hexa);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
